sar_avg_bcd: RTL

//  Downstream of the PWM SAR converter: consumes each 8-bit conversion result (result + 1-cycle valid),

---
 rtl/sar_adc_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/sar_avg_bcd.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared widths, converter state encoding and the double-dabble step
// used by the SAR averaging / BCD display path.
package sar_adc_pkg;
    localparam int ADC_W      = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 12;
    localparam int WORK_W     = BCD_W + ADC_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_PRESENT
    } avg_state_t;

    // One double-dabble iteration on {bcd, bin}: correct digits >= 5, then shift left.
    function automatic logic [WORK_W-1:0] dd_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[ADC_W+4*d +: 4] >= 4'd5)
                t[ADC_W+4*d +: 4] = t[ADC_W+4*d +: 4] + 4'd3;
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (8 double-dabble iterations).
// A start while busy restarts the conversion with the new operand.
module bin2bcd_seq
    import sar_adc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADC_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    avg_state_t        state, state_nx;
    logic [2:0]        iter;
    logic [WORK_W-1:0] work, work_nx;

    assign work_nx = dd_step(work);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state == S_LOAD) || (state == S_SHIFT);
        // done marks the edge that completes the last iteration; bcd is valid alongside it
        done     = (state == S_SHIFT) && (iter == 3'd7) && !start;
        bcd      = work_nx[WORK_W-1 -: BCD_W];
        if (start) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_IDLE:    state_nx = S_IDLE;
                S_LOAD:    state_nx = S_SHIFT;
                S_SHIFT:   if (iter == 3'd7) state_nx = S_PRESENT;
                S_PRESENT: state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work <= '0;
            iter <= '0;
        end else if (state == S_LOAD) begin
            work <= {{BCD_W{1'b0}}, bin};
            iter <= '0;
        end else if (state == S_SHIFT) begin
            work <= work_nx;
            iter <= iter + 3'd1;
        end
    end
endmodule

// File: rtl/sar_avg_bcd.sv
// Block-averages 2**LOG2_N SAR results, rounds, and presents avg + BCD digits.
// Optional per-window min/max outputs when SAR_MINMAX_EN is defined.
module sar_avg_bcd
    import sar_adc_pkg::*;
#(
    parameter int LOG2_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ADC_W-1:0] in_data,
    input  logic             clear,
    output logic [ADC_W-1:0] avg,
    output logic [BCD_W-1:0] bcd,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
`ifdef SAR_MINMAX_EN
    ,
    output logic [ADC_W-1:0] win_min,
    output logic [ADC_W-1:0] win_max
`endif
);
    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = ADC_W + LOG2_N;
    localparam int HALF  = N / 2;

    logic [ACC_W-1:0] acc, sum_q, sum_nx;
    logic [ACC_W:0]   rsum;
    logic [6:0]       count;
    logic             last, win_done;
    logic [ADC_W-1:0] avg_new;
    logic             conv_busy, conv_done;
    logic [BCD_W-1:0] conv_bcd;

    assign last    = (count == 7'(N - 1));
    assign sum_nx  = acc + ACC_W'(in_data);
    assign rsum    = {1'b0, sum_q} + (ACC_W + 1)'(HALF);
    assign avg_new = ADC_W'(rsum >> LOG2_N);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            count    <= '0;
            sum_q    <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (clear) begin
                acc   <= '0;
                count <= '0;
            end else if (in_valid) begin
                if (last) begin
                    sum_q    <= sum_nx;
                    acc      <= '0;
                    count    <= '0;
                    win_done <= 1'b1;
                end else begin
                    acc   <= sum_nx;
                    count <= count + 7'd1;
                end
            end
        end
    end

    // sum_q only moves together with a restart, so avg_new at conv_done is the converted value
    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (win_done),
        .bin   (avg_new),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy = conv_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg       <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= conv_done;
            if (conv_done) begin
                avg <= avg_new;
                bcd <= conv_bcd;
            end
            if (win_done && conv_busy) overrun <= 1'b1;
        end
    end

`ifdef SAR_MINMAX_EN
    logic [ADC_W-1:0] run_min, run_max, pend_min, pend_max, mn, mx;

    assign mn = (in_data < run_min) ? in_data : run_min;
    assign mx = (in_data > run_max) ? in_data : run_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_min  <= '1;
            run_max  <= '0;
            pend_min <= '1;
            pend_max <= '0;
            win_min  <= '1;
            win_max  <= '0;
        end else begin
            if (clear) begin
                run_min <= '1;
                run_max <= '0;
            end else if (in_valid) begin
                if (last) begin
                    pend_min <= mn;
                    pend_max <= mx;
                    run_min  <= '1;
                    run_max  <= '0;
                end else begin
                    run_min <= mn;
                    run_max <= mx;
                end
            end
            if (conv_done) begin
                win_min <= pend_min;
                win_max <= pend_max;
            end
        end
    end
`endif
endmodule
